// File: rtl/usb_bus_bridge_if.sv
// Host-side bus of the USB OTG chip bridge.
// Carries address, write data, strobes, read data and wait.
interface usb_bus_bridge_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] iADDR;
    logic [DATA_W-1:0] iDATA;
    logic              iCS_N;
    logic              iRD_N;
    logic              iWR_N;
    logic [DATA_W-1:0] oDATA;
    logic              oWAIT_N;

    modport master (
        output iADDR, iDATA, iCS_N, iRD_N, iWR_N,
        input  oDATA, oWAIT_N
    );

    modport slave (
        input  iADDR, iDATA, iCS_N, iRD_N, iWR_N,
        output oDATA, oWAIT_N
    );
endinterface

// File: rtl/usb_bus_bridge.sv
// Host bus to USB OTG chip bridge: timed CS/RD/WR cycles, reset stretch,
// interrupt sync. Ports: iCLK, iRST_N, bus (host), OTG_* (chip), oINT_N.
module usb_bus_bridge #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 2,
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 3,
    parameter int HOLD_CYC     = 1,
    parameter int RST_CYC      = 8,
    parameter int N_INT        = 2,
    parameter bit INT_ACT_HIGH = 1'b0
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    usb_bus_bridge_if.slave   bus,
    output logic [N_INT-1:0]  oINT_N,
    output logic [ADDR_W-1:0] OTG_ADDR,
    inout  wire  [DATA_W-1:0] OTG_DATA,
    output logic              OTG_CS_N,
    output logic              OTG_RD_N,
    output logic              OTG_WR_N,
    output logic              OTG_RST_N,
    input  logic [N_INT-1:0]  OTG_INT
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STB_LAST   = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);
    localparam logic [7:0] RST_LAST   = 8'(RST_CYC - 1);
    localparam logic [N_INT-1:0] SYNC_IDLE = INT_ACT_HIGH ? '0 : '1;

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              armed;
    logic              is_rd, is_rd_n;
    logic              accept;
    logic              start;
    logic              bus_act;
    logic              cap_rd;
    logic              drv_en;
    logic              wait_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [7:0]        rst_cnt;
    logic [N_INT-1:0]  sync1, sync2;

    // OTG_RST_N doubles as "stretch finished"; nothing starts before it.
    assign start = OTG_RST_N && armed && !bus.iCS_N
                   && (bus.iRD_N ^ bus.iWR_N);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        is_rd_n = is_rd;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    is_rd_n = !bus.iRD_N;
                    if (SETUP_CYC != 0) begin
                        state_n = SETUP;
                        cnt_n   = SETUP_LAST;
                    end else begin
                        state_n = STROBE;
                        cnt_n   = STB_LAST;
                    end
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_n = STROBE;
                    cnt_n   = STB_LAST;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    if (HOLD_CYC != 0) begin
                        state_n = HOLD;
                        cnt_n   = HOLD_LAST;
                    end else begin
                        state_n = DONE;
                        cnt_n   = 4'd0;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    state_n = DONE;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    assign bus_act = (state_n == SETUP) || (state_n == STROBE)
                     || (state_n == HOLD);
    assign cap_rd  = (state == STROBE) && (cnt == 4'd0) && is_rd;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            armed    <= 1'b1;
            is_rd    <= 1'b0;
            OTG_ADDR <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            OTG_CS_N <= 1'b1;
            OTG_RD_N <= 1'b1;
            OTG_WR_N <= 1'b1;
            drv_en   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            is_rd <= is_rd_n;
            if (bus.iCS_N) begin
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end
            if (accept) begin
                OTG_ADDR <= bus.iADDR;
                wdata_q  <= bus.iDATA;
            end
            if (cap_rd) begin
                rdata_q <= OTG_DATA;
            end
            OTG_CS_N <= !bus_act;
            OTG_RD_N <= !((state_n == STROBE) && is_rd_n);
            OTG_WR_N <= !((state_n == STROBE) && !is_rd_n);
            drv_en   <= bus_act && !is_rd_n;
        end
    end

    // Chip reset stretch; wait stays low until the chip is out of reset.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rst_cnt   <= 8'd0;
            OTG_RST_N <= 1'b0;
            wait_q    <= 1'b0;
        end else if (!OTG_RST_N) begin
            rst_cnt <= rst_cnt + 8'd1;
            if (rst_cnt == RST_LAST) begin
                OTG_RST_N <= 1'b1;
                wait_q    <= 1'b1;
            end
        end else if (accept) begin
            wait_q <= 1'b0;
        end else if ((state_n == DONE) && (state != DONE)) begin
            wait_q <= 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
        end else begin
            sync1 <= OTG_INT;
            sync2 <= sync1;
        end
    end

    assign oINT_N      = INT_ACT_HIGH ? ~sync2 : sync2;
    assign OTG_DATA    = drv_en ? wdata_q : {DATA_W{1'bz}};
    assign bus.oDATA   = rdata_q;
    assign bus.oWAIT_N = wait_q;
endmodule
